// File: rtl/fpu_issue_rf.sv
// FP register file with per-register scoreboard, issue to NUNIT units, writeback arbiter.
// Define FPU_ZERO_REG_EN to hardwire register 0 to zero.
module fpu_issue_rf #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NUNIT = 4,
  parameter int OPW   = 6,
  localparam int RW   = $clog2(NREG),
  localparam int UW   = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_kind,
  input  logic [UW-1:0]         cmd_unit,
  input  logic [OPW-1:0]        cmd_op,
  input  logic                  cmd_wr,
  input  logic [RW-1:0]         cmd_rs1,
  input  logic [RW-1:0]         cmd_rs2,
  input  logic [RW-1:0]         cmd_rd,
  input  logic [XLEN-1:0]       cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_flag,
  output logic [NUNIT-1:0]      u_req,
  output logic [NUNIT*OPW-1:0]  u_op,
  output logic [NUNIT*XLEN-1:0] u_x1,
  output logic [NUNIT*XLEN-1:0] u_x2,
  output logic [NUNIT*XLEN-1:0] u_imm,
  input  logic [NUNIT-1:0]      u_done,
  input  logic [NUNIT*XLEN-1:0] u_res,
  input  logic [NUNIT-1:0]      u_flag,
  output logic [NUNIT-1:0]      u_ack
);

  typedef enum logic [1:0] {
    K_EXEC = 2'b00,
    K_MOV  = 2'b01,
    K_SET  = 2'b10,
    K_GET  = 2'b11
  } kind_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_e;

  logic [XLEN-1:0]       rf_q [NREG];
  logic [XLEN-1:0]       rf_d [NREG];
  logic [NREG-1:0]       pend_q, pend_d;
  ch_e                   ch_q [NUNIT];
  ch_e                   ch_d [NUNIT];
  logic [RW-1:0]         rd_q [NUNIT];
  logic [RW-1:0]         rd_d [NUNIT];
  logic [NUNIT-1:0]      wr_q, wr_d;
  logic [NUNIT-1:0]      u_req_q, u_req_d;
  logic [NUNIT*OPW-1:0]  op_q, op_d;
  logic [NUNIT*XLEN-1:0] x1_q, x1_d;
  logic [NUNIT*XLEN-1:0] x2_q, x2_d;
  logic [NUNIT*XLEN-1:0] imm_q, imm_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]       rsp_data_q, rsp_data_d;
  logic                  rsp_flag_q, rsp_flag_d;

  logic                  rsp_free;
  logic                  wb_hit;
  logic [NUNIT-1:0]      wb_oh;
  logic                  wb_wr;
  logic [RW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_res;
  logic                  wb_flag;
  logic                  wb_rf;
  logic                  wb_rsp;
  logic                  unit_idle;
  logic                  ok;
  logic                  acc;
  logic [XLEN-1:0]       src1;
  logic [XLEN-1:0]       src2;

  // Lowest-index finished unit whose destination can take the result
  always_comb begin
    rsp_free = !rsp_valid_q || rsp_ready;
    wb_hit   = 1'b0;
    wb_oh    = '0;
    wb_wr    = 1'b0;
    wb_rd    = '0;
    wb_res   = '0;
    wb_flag  = 1'b0;
    for (int i = 0; i < NUNIT; i++) begin
      if (!wb_hit && ch_q[i] == CH_BUSY && u_done[i] &&
          (wr_q[i] || rsp_free)) begin
        wb_hit   = 1'b1;
        wb_oh[i] = 1'b1;
        wb_wr    = wr_q[i];
        wb_rd    = rd_q[i];
        wb_res   = u_res[i*XLEN +: XLEN];
        wb_flag  = u_flag[i];
      end
    end
    wb_rf  = wb_hit && wb_wr;
    wb_rsp = wb_hit && !wb_wr;
  end

  always_comb begin
    src1      = rf_q[cmd_rs1];
    src2      = rf_q[cmd_rs2];
    unit_idle = 1'b0;
    for (int i = 0; i < NUNIT; i++) begin
      if (UW'(i) == cmd_unit)
        unit_idle = (ch_q[i] == CH_IDLE);
    end
    ok = 1'b0;
    unique case (kind_e'(cmd_kind))
      K_EXEC: ok = !pend_q[cmd_rs1] && !pend_q[cmd_rs2] &&
                   !(cmd_wr && pend_q[cmd_rd]) && unit_idle;
      K_MOV:  ok = !pend_q[cmd_rs1] && !pend_q[cmd_rd] && !wb_rf;
      K_SET:  ok = !pend_q[cmd_rd] && !wb_rf;
      K_GET:  ok = !pend_q[cmd_rs1] && rsp_free && !wb_rsp;
    endcase
    cmd_ready = rstn && ok;
    acc       = cmd_valid && cmd_ready;
  end

  always_comb begin
    rf_d        = rf_q;
    pend_d      = pend_q;
    ch_d        = ch_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    u_req_d     = '0;
    op_d        = op_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    imm_d       = imm_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    if (rsp_valid_q && rsp_ready)
      rsp_valid_d = 1'b0;
    for (int i = 0; i < NUNIT; i++) begin
      if (wb_oh[i])
        ch_d[i] = CH_IDLE;
    end
    if (wb_rf) begin
      pend_d[wb_rd] = 1'b0;
      rf_d[wb_rd]   = wb_res;
    end
    if (wb_rsp) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = wb_res;
      rsp_flag_d  = wb_flag;
    end
    if (acc) begin
      unique case (kind_e'(cmd_kind))
        K_EXEC: begin
          for (int i = 0; i < NUNIT; i++) begin
            if (UW'(i) == cmd_unit) begin
              ch_d[i]                = CH_BUSY;
              rd_d[i]                = cmd_rd;
              wr_d[i]                = cmd_wr;
              u_req_d[i]             = 1'b1;
              op_d[i*OPW +: OPW]     = cmd_op;
              x1_d[i*XLEN +: XLEN]   = src1;
              x2_d[i*XLEN +: XLEN]   = src2;
              imm_d[i*XLEN +: XLEN]  = cmd_data;
            end
          end
          if (cmd_wr)
            pend_d[cmd_rd] = 1'b1;
        end
        K_MOV: rf_d[cmd_rd] = src1;
        K_SET: rf_d[cmd_rd] = cmd_data;
        K_GET: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = src1;
          rsp_flag_d  = 1'b0;
        end
      endcase
    end
`ifdef FPU_ZERO_REG_EN
    rf_d[0]   = '0;
    pend_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
      for (int i = 0; i < NUNIT; i++) begin
        ch_q[i] <= CH_IDLE;
        rd_q[i] <= '0;
      end
      pend_q      <= '0;
      wr_q        <= '0;
      u_req_q     <= '0;
      op_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      imm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      ch_q        <= ch_d;
      rd_q        <= rd_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      u_req_q     <= u_req_d;
      op_q        <= op_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      imm_q       <= imm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign u_req     = u_req_q;
  assign u_op      = op_q;
  assign u_x1      = x1_q;
  assign u_x2      = x2_q;
  assign u_imm     = imm_q;
  assign u_ack     = rstn ? wb_oh : '0;

endmodule

// File: tb/tb_fpu_issue_rf.sv
// Directed bench for fpu_issue_rf: issue, scoreboard stalls, writeback order, reset.
module tb_fpu_issue_rf;

  localparam logic [1:0] K_EXEC = 2'b00;
  localparam logic [1:0] K_MOV  = 2'b01;
  localparam logic [1:0] K_SET  = 2'b10;
  localparam logic [1:0] K_GET  = 2'b11;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_kind;
  logic [1:0]   cmd_unit;
  logic [5:0]   cmd_op;
  logic         cmd_wr;
  logic [4:0]   cmd_rs1;
  logic [4:0]   cmd_rs2;
  logic [4:0]   cmd_rd;
  logic [31:0]  cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_flag;
  logic [3:0]   u_req;
  logic [23:0]  u_op;
  logic [127:0] u_x1;
  logic [127:0] u_x2;
  logic [127:0] u_imm;
  logic [3:0]   u_done;
  logic [127:0] u_res;
  logic [3:0]   u_flag;
  logic [3:0]   u_ack;

  int checks = 0;
  int errors = 0;
  int w;
  logic [31:0] zexp;

  fpu_issue_rf dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_unit(cmd_unit),
    .cmd_op(cmd_op), .cmd_wr(cmd_wr),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .u_req(u_req), .u_op(u_op),
    .u_x1(u_x1), .u_x2(u_x2), .u_imm(u_imm),
    .u_done(u_done), .u_res(u_res),
    .u_flag(u_flag), .u_ack(u_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] k, input logic [1:0] u,
                       input logic [5:0] op, input logic wr,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_unit  = u;
    cmd_op    = op;
    cmd_wr    = wr;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rd    = rd;
    cmd_data  = d;
  endtask

  task automatic wait_acc(output int n);
    n = 0;
    #1;
    while (!cmd_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    if (!cmd_ready)
      chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] k, input logic [1:0] u,
                      input logic [5:0] op, input logic wr,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] d,
                      output int n);
    drive(k, u, op, wr, rs1, rs2, rd, d);
    wait_acc(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_kind = K_EXEC; cmd_unit = 2'd0;
    cmd_op = 6'd0; cmd_wr = 1'b0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
    cmd_rd = 5'd0; cmd_data = 32'd0;
    u_done = 4'd0; u_res = 128'd0; u_flag = 4'd0;

    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_flag", 64'(rsp_flag), 64'(0));
    chk("rst_u_req", 64'(u_req), 64'(0));
    chk("rst_u_ack", 64'(u_ack), 64'(0));
    step();
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);

    send(K_SET, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h3F800000, w);
    chk("set_wait", 64'(w), 64'(0));
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0, w);
    chk("get_wait", 64'(w), 64'(0));
    chk("get_valid", 64'(rsp_valid), 64'(1));
    chk("get_data", 64'(rsp_data), 64'h3F800000);
    chk("get_flag", 64'(rsp_flag), 64'(0));
    step();
    chk("rsp_drain", 64'(rsp_valid), 64'(0));

    send(K_EXEC, 2'd0, 6'd1, 1'b1, 5'd3, 5'd3, 5'd5, 32'h55, w);
    chk("exec_req", 64'(u_req), 64'h1);
    chk("exec_x1", 64'(u_x1[31:0]), 64'h3F800000);
    chk("exec_x2", 64'(u_x2[31:0]), 64'h3F800000);
    chk("exec_op", 64'(u_op[5:0]), 64'h1);
    chk("exec_imm", 64'(u_imm[31:0]), 64'h55);
    drive(K_GET, 2'd0, 6'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
    #1;
    chk("get_r5_stall", 64'(cmd_ready), 64'(0));
    step();
    #1;
    chk("u_req_pulse", 64'(u_req), 64'(0));
    step();
    step();
    u_done = 4'b0001;
    u_res[31:0] = 32'h40000000;
    #1;
    chk("ack_u0", 64'(u_ack), 64'h1);
    chk("get_no_bypass", 64'(cmd_ready), 64'(0));
    chk("x1_held", 64'(u_x1[31:0]), 64'h3F800000);
    step();
    u_done = 4'b0000;
    #1;
    chk("get_after_ack", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("get_r5_valid", 64'(rsp_valid), 64'(1));
    chk("get_r5_data", 64'(rsp_data), 64'h40000000);

    send(K_EXEC, 2'd0, 6'd2, 1'b1, 5'd3, 5'd3, 5'd6, 32'd0, w);
    send(K_EXEC, 2'd1, 6'd3, 1'b1, 5'd3, 5'd3, 5'd7, 32'd0, w);
    chk("exec_u1_wait", 64'(w), 64'(0));
    u_done = 4'b0011;
    u_res[31:0]  = 32'h11111111;
    u_res[63:32] = 32'h22222222;
    #1;
    chk("dual_ack_first", 64'(u_ack), 64'h1);
    step();
    u_done = 4'b0010;
    #1;
    chk("dual_ack_second", 64'(u_ack), 64'h2);
    step();
    u_done = 4'b0000;
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd0, w);
    chk("get_r6", 64'(rsp_data), 64'h11111111);
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0, w);
    chk("get_r7", 64'(rsp_data), 64'h22222222);

    send(K_EXEC, 2'd0, 6'd4, 1'b1, 5'd3, 5'd3, 5'd10, 32'd0, w);
    drive(K_MOV, 2'd0, 6'd0, 1'b0, 5'd3, 5'd0, 5'd11, 32'd0);
    u_done = 4'b0001;
    u_res[31:0] = 32'h33333333;
    #1;
    chk("mov_blocked", 64'(cmd_ready), 64'(0));
    chk("mov_wb_ack", 64'(u_ack), 64'h1);
    step();
    u_done = 4'b0000;
    wait_acc(w);
    chk("mov_wait", 64'(w), 64'(0));
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd11, 5'd0, 5'd0, 32'd0, w);
    chk("get_r11", 64'(rsp_data), 64'h3F800000);
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd0, w);
    chk("get_r10", 64'(rsp_data), 64'h33333333);
    step();

    send(K_EXEC, 2'd2, 6'd5, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0, w);
    rsp_ready = 1'b0;
    drive(K_GET, 2'd0, 6'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
    u_done = 4'b0100;
    u_flag = 4'b0100;
    u_res[95:64] = 32'hCAFEBABE;
    #1;
    chk("rsp_wb_ack", 64'(u_ack), 64'h4);
    chk("get_vs_wb", 64'(cmd_ready), 64'(0));
    step();
    u_done = 4'b0000;
    u_flag = 4'b0000;
    #1;
    chk("wb_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wb_rsp_data", 64'(rsp_data), 64'hCAFEBABE);
    chk("wb_rsp_flag", 64'(rsp_flag), 64'(1));
    chk("get_rsp_full", 64'(cmd_ready), 64'(0));
    step();
    step();
    #1;
    chk("rsp_hold_data", 64'(rsp_data), 64'hCAFEBABE);
    chk("rsp_hold_flag", 64'(rsp_flag), 64'(1));
    rsp_ready = 1'b1;
    wait_acc(w);
    chk("get_after_drain", 64'(w), 64'(0));
    chk("get2_valid", 64'(rsp_valid), 64'(1));
    chk("get2_data", 64'(rsp_data), 64'h3F800000);
    chk("get2_flag", 64'(rsp_flag), 64'(0));
    step();

    rsp_ready = 1'b0;
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0, w);
    send(K_EXEC, 2'd0, 6'd1, 1'b1, 5'd3, 5'd3, 5'd8, 32'd0, w);
    send(K_EXEC, 2'd1, 6'd1, 1'b1, 5'd3, 5'd3, 5'd9, 32'd0, w);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    u_done = 4'b0010;
    drive(K_EXEC, 2'd0, 6'd1, 1'b1, 5'd8, 5'd9, 5'd8, 32'd0);
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("mid_rst_u_req", 64'(u_req), 64'(0));
    chk("mid_rst_no_ack", 64'(u_ack), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b0;
    u_done = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0, w);
    chk("mid_rst_r3", 64'(rsp_data), 64'(0));

`ifdef FPU_ZERO_REG_EN
    zexp = 32'h00000000;
`else
    zexp = 32'h12345678;
`endif
    send(K_SET, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h12345678, w);
    send(K_GET, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, w);
    chk("zero_reg", 64'(rsp_data), 64'(zexp));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
